// File: rtl/adc_capture_sequencer_if.sv
`default_nettype none
// =====================================================================
// Module  : adc_capture_sequencer_if
// Purpose : Control, ADC sample, FIFO write and status bundle of the sequencer.
// Revision: 1.0  initial release
// =====================================================================
interface adc_capture_sequencer_if #(
   parameter int DATA_W  = 16,
   parameter int COUNT_W = 24
);
   logic                  arm;
   logic                  abort;
   logic [COUNT_W-1:0]    capture_len;
   logic [1:0]            trig_mode;
   logic [DATA_W-1:0]     trig_level;
   logic [DATA_W-1:0]     adc_data_1;
   logic [DATA_W-1:0]     adc_data_2;
   logic                  data_valid;
   logic                  sys_ready;
   logic                  fifo_prog_full;
   logic                  fifo_rst_busy;
   logic [2*DATA_W-1:0]   fifo_din;
   logic                  fifo_wr_en;
   logic                  busy;
   logic                  done;
   logic                  overflow;
   logic                  link_err;
   logic [COUNT_W-1:0]    words_written;

   modport master (
      output arm, abort, capture_len, trig_mode, trig_level,
             adc_data_1, adc_data_2, data_valid, sys_ready,
             fifo_prog_full, fifo_rst_busy,
      input  fifo_din, fifo_wr_en, busy, done, overflow, link_err, words_written
   );

   modport slave (
      input  arm, abort, capture_len, trig_mode, trig_level,
             adc_data_1, adc_data_2, data_valid, sys_ready,
             fifo_prog_full, fifo_rst_busy,
      output fifo_din, fifo_wr_en, busy, done, overflow, link_err, words_written
   );
endinterface
`default_nettype wire

// File: rtl/adc_capture_sequencer.sv
`default_nettype none
// =====================================================================
// Module  : adc_capture_sequencer
// Purpose : Arms, triggers and writes one fixed-length ADC capture to the FIFO.
// Revision: 1.0  initial release
// =====================================================================
module adc_capture_sequencer #(
   parameter int DATA_W  = 16,
   parameter int COUNT_W = 24
) (
   input  wire logic               adc_data_clk,
   input  wire logic               reset,
   adc_capture_sequencer_if.slave  bus_if
);
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_RDY  = 3'd1,
      S_WAIT_TRIG = 3'd2,
      S_CAPTURE   = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   state_t                    state_q;
   logic [COUNT_W-1:0]        len_q;
   logic [COUNT_W-1:0]        words_q;
   logic signed [DATA_W-1:0]  level_q;
   logic signed [DATA_W-1:0]  prev_q;
   logic [1:0]                mode_q;
   logic                      prev_vld_q;
   logic [1:0]                dv_low_q;
   logic [2*DATA_W-1:0]       din_q;
   logic                      wr_en_q;
   logic                      done_q;
   logic                      ovf_q;
   logic                      link_q;

   logic signed [DATA_W-1:0]  cur_d;
   logic                      trig_hit_d;
   logic                      take_d;
   logic                      can_write_d;
   logic [COUNT_W-1:0]        words_inc_d;

   always_comb begin
      trig_hit_d  = 1'b0;
      cur_d       = $signed(bus_if.adc_data_1);
      case (mode_q)
         2'b01:   trig_hit_d = prev_vld_q && (prev_q < level_q) && (cur_d >= level_q);
         2'b10:   trig_hit_d = prev_vld_q && (prev_q > level_q) && (cur_d <= level_q);
         default: trig_hit_d = 1'b1;
      endcase
      can_write_d = !bus_if.fifo_prog_full && !bus_if.fifo_rst_busy;
      // The triggering sample is itself word 0, so it is taken in WAIT_TRIG.
      take_d      = bus_if.sys_ready && bus_if.data_valid &&
                    ((state_q == S_CAPTURE) || ((state_q == S_WAIT_TRIG) && trig_hit_d));
      words_inc_d = words_q + 1'b1;
   end

   always_ff @(posedge adc_data_clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         words_q    <= '0;
         level_q    <= '0;
         prev_q     <= '0;
         mode_q     <= 2'b00;
         prev_vld_q <= 1'b0;
         dv_low_q   <= 2'd0;
         din_q      <= '0;
         wr_en_q    <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         link_q     <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         if (bus_if.abort) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE, S_DONE: begin
                  if (bus_if.arm) begin
                     len_q   <= bus_if.capture_len;
                     level_q <= $signed(bus_if.trig_level);
                     mode_q  <= bus_if.trig_mode;
                     ovf_q   <= 1'b0;
                     link_q  <= 1'b0;
                     words_q <= '0;
                     if (bus_if.capture_len == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= S_WAIT_RDY;
                        done_q  <= 1'b0;
                     end
                  end
               end
               S_WAIT_RDY: begin
                  if (bus_if.sys_ready && bus_if.data_valid && !bus_if.fifo_rst_busy) begin
                     state_q    <= S_WAIT_TRIG;
                     prev_vld_q <= 1'b0;
                  end
               end
               S_WAIT_TRIG: begin
                  if (!bus_if.sys_ready) begin
                     link_q  <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else if (bus_if.data_valid && !trig_hit_d) begin
                     prev_q     <= cur_d;
                     prev_vld_q <= 1'b1;
                  end else if (bus_if.data_valid) begin
                     state_q  <= S_CAPTURE;
                     dv_low_q <= 2'd0;
                  end
               end
               S_CAPTURE: begin
                  if (!bus_if.sys_ready) begin
                     link_q  <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else if (bus_if.data_valid) begin
                     dv_low_q <= 2'd0;
                  end else if (dv_low_q == 2'd3) begin
                     link_q <= 1'b1;
                  end else begin
                     dv_low_q <= dv_low_q + 2'd1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase

            if (take_d) begin
               if (can_write_d) begin
                  wr_en_q <= 1'b1;
                  din_q   <= {bus_if.adc_data_1, bus_if.adc_data_2};
                  words_q <= words_inc_d;
                  if (words_inc_d == len_q) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end else begin
                  ovf_q <= 1'b1;
               end
            end
         end
      end
   end

   assign bus_if.fifo_din      = din_q;
   assign bus_if.fifo_wr_en    = wr_en_q;
   assign bus_if.busy          = (state_q == S_WAIT_RDY) || (state_q == S_WAIT_TRIG) ||
                                 (state_q == S_CAPTURE);
   assign bus_if.done          = done_q;
   assign bus_if.overflow      = ovf_q;
   assign bus_if.link_err      = link_q;
   assign bus_if.words_written = words_q;
endmodule
`default_nettype wire
